// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: rotation schedule, PC1/PC2
// permutation tables and functions, 28-bit rotators, scheduler state type
// and the slot-index width helper used by the interface and the modules.
package des_pkg;

   localparam int unsigned KEY_W      = 64;
   localparam int unsigned HALF_W     = 28;
   localparam int unsigned CD_W       = 56;
   localparam int unsigned SK_W       = 48;
   localparam int unsigned ROUND_W    = 4;
   localparam int unsigned NUM_ROUNDS = 16;

   // Left-rotation amount applied to C,D before round i+1 (index 0 = round 1)
   localparam int unsigned SHIFT_SCHEDULE [NUM_ROUNDS] =
      '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // Key bit numbers (1 = MSB) feeding C0 (first 28) then D0 (last 28)
   localparam int unsigned PC1_TABLE [CD_W] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   // C||D bit numbers (1 = MSB) selected into the 48-bit subkey
   localparam int unsigned PC2_TABLE [SK_W] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   typedef enum logic [0:0] {
      SCHED_IDLE = 1'b0,
      SCHED_RUN  = 1'b1
   } sched_state_e;

   // Slot index width: clog2 of the slot count, never narrower than 1 bit
   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // PC1: 64-bit key to C0||D0, parity bits dropped
   function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
      logic [CD_W-1:0] cd;
      cd = '0;
      for (int i = 0; i < int'(CD_W); i++)
         cd[6'(int'(CD_W) - 1 - i)] = key[6'(int'(KEY_W) - int'(PC1_TABLE[i]))];
      return cd;
   endfunction

   // PC2: C||D to 48-bit round subkey
   function automatic logic [SK_W-1:0] pc2(input logic [CD_W-1:0] cd);
      logic [SK_W-1:0] sk;
      sk = '0;
      for (int i = 0; i < int'(SK_W); i++)
         sk[6'(int'(SK_W) - 1 - i)] = cd[6'(int'(CD_W) - int'(PC2_TABLE[i]))];
      return sk;
   endfunction

   function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                               input logic [1:0] n);
      case (n)
         2'd1:    return {x[HALF_W-2:0], x[HALF_W-1]};
         2'd2:    return {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
         default: return x;
      endcase
   endfunction

   function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                               input logic [1:0] n);
      case (n)
         2'd1:    return {x[0], x[HALF_W-1:1]};
         2'd2:    return {x[1:0], x[HALF_W-1:2]};
         default: return x;
      endcase
   endfunction

endpackage

// File: rtl/des_subkey_scheduler_if.sv
// Run-request and subkey-stream handshake bundle of the DES subkey scheduler.
//   start_*  : requester asks for a run on slot start_sel, encrypt/decrypt order
//   sk_*     : one subkey per accepted beat, with round index, last flag, slot
// master = requester/consumer side, slave = scheduler side.
interface des_subkey_scheduler_if #(
   parameter int unsigned NUM_KEYS = 3
);
   import des_pkg::*;

   localparam int unsigned SEL_W = sel_width(NUM_KEYS);

   logic               start_valid;
   logic               start_ready;
   logic [SEL_W-1:0]   start_sel;
   logic               start_decrypt;
   logic               sk_valid;
   logic               sk_ready;
   logic [SK_W-1:0]    subkey;
   logic [ROUND_W-1:0] sk_round;
   logic               sk_last;
   logic [SEL_W-1:0]   sk_sel;

   modport master (
      output start_valid, start_sel, start_decrypt, sk_ready,
      input  start_ready, sk_valid, subkey, sk_round, sk_last, sk_sel
   );

   modport slave (
      input  start_valid, start_sel, start_decrypt, sk_ready,
      output start_ready, sk_valid, subkey, sk_round, sk_last, sk_sel
   );

endinterface

// File: rtl/des_key_slot_bank.sv
// Key slot bank: stores PC1(key) as C0||D0 per slot and flags weak keys.
//   clk, rst_n  : clock, async active-low reset (clears slots and flags)
//   key_wr      : write strobe, key_wr_sel selects slot, out-of-range ignored
//   key_in      : 64-bit DES key, parity bits unused
//   rd_sel      : read slot index, rd_cd returns its C0||D0 (0 if out of range)
//   key_weak    : per-slot weak-key flag
// Optional feature macro: DES_WEAK_KEY_CHECK_EN (without it key_weak is 0).
module des_key_slot_bank
   import des_pkg::*;
#(
   parameter int unsigned NUM_KEYS = 3
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                key_wr,
   input  logic [sel_width(NUM_KEYS)-1:0]      key_wr_sel,
   input  logic [KEY_W-1:0]                    key_in,
   input  logic [sel_width(NUM_KEYS)-1:0]      rd_sel,
   output logic [CD_W-1:0]                     rd_cd,
   output logic [NUM_KEYS-1:0]                 key_weak
);

   localparam int unsigned SEL_W = sel_width(NUM_KEYS);

   logic [CD_W-1:0] slot_q [NUM_KEYS];
   logic [CD_W-1:0] wr_cd;

   always_comb wr_cd = pc1(key_in);

   // Slot registers; index compare per slot makes out-of-range writes no-ops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_KEYS); i++)
            slot_q[i] <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_KEYS); i++)
            if (key_wr && (key_wr_sel == SEL_W'(i)))
               slot_q[i] <= wr_cd;
      end
   end

   // Read port sees the registered contents, so a same-cycle write is not visible
   always_comb begin
      rd_cd = '0;
      for (int i = 0; i < int'(NUM_KEYS); i++)
         if (rd_sel == SEL_W'(i))
            rd_cd = slot_q[i];
   end

`ifdef DES_WEAK_KEY_CHECK_EN
   logic                wr_weak;
   logic [NUM_KEYS-1:0] weak_q;

   // Weak when each half is uniformly 0 or 1
   always_comb begin
      wr_weak = ((&wr_cd[CD_W-1:HALF_W]) || (~|wr_cd[CD_W-1:HALF_W])) &&
                ((&wr_cd[HALF_W-1:0])    || (~|wr_cd[HALF_W-1:0]));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         weak_q <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_KEYS); i++)
            if (key_wr && (key_wr_sel == SEL_W'(i)))
               weak_q[i] <= wr_weak;
      end
   end

   assign key_weak = weak_q;
`else
   assign key_weak = '0;
`endif

endmodule

// File: rtl/des_subkey_scheduler.sv
// DES key-schedule engine: streams the 16 round subkeys of a stored key slot,
// one per handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
//   clk, rst_n           : clock, async active-low reset
//   key_wr/key_wr_sel/key_in : slot bank write port
//   bus (slave)          : start request handshake and subkey stream
//   busy                 : a run is in progress
//   key_weak             : per-slot weak-key flag
// Optional feature macro: DES_WEAK_KEY_CHECK_EN (weak-key flagging).
module des_subkey_scheduler
   import des_pkg::*;
#(
   parameter int unsigned NUM_KEYS = 3
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             key_wr,
   input  logic [sel_width(NUM_KEYS)-1:0]   key_wr_sel,
   input  logic [KEY_W-1:0]                 key_in,
   des_subkey_scheduler_if.slave            bus,
   output logic                             busy,
   output logic [NUM_KEYS-1:0]              key_weak
);

   localparam int unsigned SEL_W = sel_width(NUM_KEYS);
   localparam logic [0:0]  ST_IDLE = SCHED_IDLE;
   localparam logic [0:0]  ST_RUN  = SCHED_RUN;
   localparam logic [ROUND_W-1:0] LAST_CNT = ROUND_W'(NUM_ROUNDS - 1);

   logic [0:0]         state_q, state_d;
   logic [HALF_W-1:0]  c_q, c_d, d_q, d_d;
   logic [ROUND_W-1:0] cnt_q, cnt_d;
   logic               dec_q, dec_d;
   logic [SEL_W-1:0]   sel_q, sel_d;

   logic [CD_W-1:0]    rd_cd;
   logic               sk_valid_c;
   logic               hs_c;
   logic               last_c;
   logic               start_ready_c;
   logic               start_acc_c;
   logic [1:0]         enc_shift_c;
   logic [1:0]         dec_shift_c;

   des_key_slot_bank #(.NUM_KEYS(NUM_KEYS)) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_wr     (key_wr),
      .key_wr_sel (key_wr_sel),
      .key_in     (key_in),
      .rd_sel     (bus.start_sel),
      .rd_cd      (rd_cd),
      .key_weak   (key_weak)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         c_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         dec_q   <= 1'b0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         dec_q   <= dec_d;
         sel_q   <= sel_d;
      end
   end

   // Next-state and handshake logic
   always_comb begin
      sk_valid_c    = (state_q == ST_RUN);
      hs_c          = sk_valid_c && bus.sk_ready;
      last_c        = (cnt_q == LAST_CNT);
      // Accepting on the final beat chains runs without a bubble
      start_ready_c = (state_q == ST_IDLE) || (hs_c && last_c);
      start_acc_c   = bus.start_valid && start_ready_c;
      enc_shift_c   = 2'(SHIFT_SCHEDULE[ROUND_W'(cnt_q + 4'd1)]);
      dec_shift_c   = 2'(SHIFT_SCHEDULE[ROUND_W'(LAST_CNT - cnt_q)]);

      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      dec_d   = dec_q;
      sel_d   = sel_q;

      if (start_acc_c) begin
         state_d = ST_RUN;
         cnt_d   = '0;
         dec_d   = bus.start_decrypt;
         sel_d   = bus.start_sel;
         // Decrypt starts from C0,D0 which equals C16,D16 (28 total shifts)
         if (bus.start_decrypt) begin
            c_d = rd_cd[CD_W-1:HALF_W];
            d_d = rd_cd[HALF_W-1:0];
         end else begin
            c_d = rotl28(rd_cd[CD_W-1:HALF_W], 2'd1);
            d_d = rotl28(rd_cd[HALF_W-1:0], 2'd1);
         end
      end else if (hs_c) begin
         if (last_c) begin
            state_d = ST_IDLE;
         end else begin
            cnt_d = cnt_q + 4'd1;
            if (dec_q) begin
               c_d = rotr28(c_q, dec_shift_c);
               d_d = rotr28(d_q, dec_shift_c);
            end else begin
               c_d = rotl28(c_q, enc_shift_c);
               d_d = rotl28(d_q, enc_shift_c);
            end
         end
      end
   end

   assign bus.sk_valid    = sk_valid_c;
   assign bus.start_ready = start_ready_c;
   assign bus.subkey      = pc2({c_q, d_q});
   assign bus.sk_round    = dec_q ? ROUND_W'(LAST_CNT - cnt_q) : cnt_q;
   assign bus.sk_last     = last_c;
   assign bus.sk_sel      = sel_q;
   assign busy            = sk_valid_c;

endmodule

// File: tb/tb_des_subkey_scheduler.sv
// Self-checking bench for des_subkey_scheduler (NUM_KEYS = 3).
module tb_des_subkey_scheduler;

   localparam int NK = 3;

`ifdef DES_WEAK_KEY_CHECK_EN
   localparam bit WEAK_ON = 1'b1;
`else
   localparam bit WEAK_ON = 1'b0;
`endif

   // Reference tables, standard DES numbering (bit 1 = MSB)
   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        key_wr;
   logic [1:0]  key_wr_sel;
   logic [63:0] key_in;
   logic        busy;
   logic [2:0]  key_weak;

   int n_pass;
   int n_total;

   des_subkey_scheduler_if #(.NUM_KEYS(NK)) bus ();

   des_subkey_scheduler #(.NUM_KEYS(NK)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_wr     (key_wr),
      .key_wr_sel (key_wr_sel),
      .key_in     (key_in),
      .bus        (bus),
      .busy       (busy),
      .key_weak   (key_weak)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Subkey of round rnd (1..16): rotate C0,D0 left by the cumulative shift
   function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int rnd);
      logic [55:0] cd;
      logic [55:0] cc;
      logic [55:0] dd;
      logic [27:0] c;
      logic [27:0] d;
      logic [47:0] sk;
      int s;
      for (int i = 0; i < 56; i++) cd[6'(55 - i)] = k[6'(64 - PC1_T[i])];
      s = 0;
      for (int j = 0; j < rnd; j++) s += SHIFT_T[j];
      s = s % 28;
      cc = {cd[55:28], cd[55:28]} << s;
      dd = {cd[27:0], cd[27:0]} << s;
      c = cc[55:28];
      d = dd[55:28];
      cd = {c, d};
      for (int i = 0; i < 48; i++) sk[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
      return sk;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_key(input int sel, input logic [63:0] k);
      key_wr     = 1'b1;
      key_wr_sel = 2'(sel);
      key_in     = k;
      step();
      key_wr     = 1'b0;
   endtask

   // One run from idle: random stalls, every beat compared against the model.
   // wr_mid >= 0 writes wr_key to the slot at that beat; wr_start writes it
   // in the same cycle as the start request.
   task automatic do_run(input int slot, input bit dec, input logic [63:0] mkey,
                         input int stall_pct, input int wr_mid, input bit wr_start,
                         input logic [63:0] wr_key,
                         output logic [47:0] first_sk, output logic [3:0] first_rnd,
                         output logic [47:0] last_sk, output logic [3:0] last_rnd);
      int hs;
      int cyc;
      int r;
      bit rdy;
      bit stalled;
      bit wr_done;
      first_sk = '0; first_rnd = '0; last_sk = '0; last_rnd = '0;
      bus.start_valid   = 1'b1;
      bus.start_sel     = 2'(slot);
      bus.start_decrypt = dec;
      bus.sk_ready      = 1'b0;
      if (wr_start) begin
         key_wr = 1'b1; key_wr_sel = 2'(slot); key_in = wr_key;
      end
      #1;
      chk("start_ready_idle", 64'(bus.start_ready), 64'd1);
      step();
      bus.start_valid = 1'b0;
      key_wr = 1'b0;
      hs = 0; cyc = 0; stalled = 1'b0; wr_done = 1'b0;
      while (hs < 16 && cyc < 400) begin
         rdy = ($urandom_range(99) >= stall_pct);
         bus.sk_ready = rdy;
         if (hs == wr_mid && !wr_done) begin
            key_wr = 1'b1; key_wr_sel = 2'(slot); key_in = wr_key; wr_done = 1'b1;
         end
         #1;
         chk("sk_valid_in_run", 64'(bus.sk_valid), 64'd1);
         if (bus.sk_valid !== 1'b1) break;
         r = dec ? 15 - hs : hs;
         chk(stalled ? "subkey_stall" : "subkey", 64'(bus.subkey), 64'(ref_subkey(mkey, r + 1)));
         chk("sk_round", 64'(bus.sk_round), 64'(r));
         chk("sk_last", 64'(bus.sk_last), 64'(hs == 15));
         chk("sk_sel", 64'(bus.sk_sel), 64'(slot));
         chk("busy", 64'(busy), 64'd1);
         if (hs == 0)  begin first_sk = bus.subkey; first_rnd = bus.sk_round; end
         if (hs == 15) begin last_sk  = bus.subkey; last_rnd  = bus.sk_round; end
         if (rdy) begin hs++; stalled = 1'b0; end
         else stalled = 1'b1;
         step();
         key_wr = 1'b0;
         cyc++;
      end
      bus.sk_ready = 1'b0;
      chk("run_handshakes", 64'(hs), 64'd16);
      #1;
      chk("idle_after_run", 64'(bus.sk_valid), 64'd0);
   endtask

   typedef struct {
      logic [63:0] key;
      int          slot;
      bit          dec;
      logic [47:0] exp_first;
      logic [3:0]  exp_first_rnd;
      logic [47:0] exp_last;
      logic [3:0]  exp_last_rnd;
   } vec_t;

   initial begin
      vec_t        vecs [4];
      logic [47:0] fs, ls;
      logic [3:0]  fr, lr;
      logic [63:0] ka, kb, kc, kw, kx;
      logic [63:0] bk [3];
      int          started, got, gap, cyc, esel;
      bit          seen;

      n_pass = 0; n_total = 0;
      key_wr = 1'b0; key_wr_sel = '0; key_in = '0;
      bus.start_valid = 1'b0; bus.start_sel = '0; bus.start_decrypt = 1'b0; bus.sk_ready = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_sk_valid", 64'(bus.sk_valid), 64'd0);
      chk("rst_start_ready", 64'(bus.start_ready), 64'd1);
      chk("rst_subkey", 64'(bus.subkey), 64'd0);
      chk("rst_sk_round", 64'(bus.sk_round), 64'd0);
      chk("rst_sk_last", 64'(bus.sk_last), 64'd0);
      chk("rst_sk_sel", 64'(bus.sk_sel), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_key_weak", 64'(key_weak), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      step();

      // Known-answer and model-derived vectors
      kx = 64'h0E329232EA6D0D73;
      vecs[0] = '{64'h133457799BBCDFF1, 0, 1'b0, 48'h1B02EFFC7072, 4'd0,  48'hCB3D8B0E17F5, 4'd15};
      vecs[1] = '{64'h133457799BBCDFF1, 1, 1'b1, 48'hCB3D8B0E17F5, 4'd15, 48'h1B02EFFC7072, 4'd0};
      vecs[2] = '{kx, 2, 1'b0, ref_subkey(kx, 1),  4'd0,  ref_subkey(kx, 16), 4'd15};
      vecs[3] = '{kx, 2, 1'b1, ref_subkey(kx, 16), 4'd15, ref_subkey(kx, 1),  4'd0};
      for (int v = 0; v < 4; v++) begin
         write_key(vecs[v].slot, vecs[v].key);
         do_run(vecs[v].slot, vecs[v].dec, vecs[v].key, 0, -1, 1'b0, 64'd0, fs, fr, ls, lr);
         chk("vec_first_subkey", 64'(fs), 64'(vecs[v].exp_first));
         chk("vec_first_round", 64'(fr), 64'(vecs[v].exp_first_rnd));
         chk("vec_last_subkey", 64'(ls), 64'(vecs[v].exp_last));
         chk("vec_last_round", 64'(lr), 64'(vecs[v].exp_last_rnd));
      end

      // Writes to the slot being scheduled
      ka = {$urandom, $urandom}; kb = {$urandom, $urandom}; kc = {$urandom, $urandom};
      write_key(1, ka);
      do_run(1, 1'b0, ka, 0, 5, 1'b0, kb, fs, fr, ls, lr);
      do_run(1, 1'b1, kb, 20, -1, 1'b0, 64'd0, fs, fr, ls, lr);
      do_run(1, 1'b0, kb, 0, -1, 1'b1, kc, fs, fr, ls, lr);
      do_run(1, 1'b0, kc, 0, -1, 1'b0, 64'd0, fs, fr, ls, lr);

      // Back-to-back runs over slots 0,1,2
      for (int i = 0; i < 3; i++) begin
         bk[i] = {$urandom, $urandom};
         write_key(i, bk[i]);
      end
      started = 0; got = 0; gap = 0; cyc = 0; seen = 1'b0;
      bus.sk_ready = 1'b1;
      while (got < 48 && cyc < 100) begin
         bus.start_valid   = (started < 3);
         bus.start_sel     = 2'(started);
         bus.start_decrypt = 1'b0;
         #1;
         if (bus.sk_valid === 1'b1) begin
            seen = 1'b1;
            esel = got / 16;
            chk("b2b_subkey", 64'(bus.subkey), 64'(ref_subkey(bk[esel], got % 16 + 1)));
            chk("b2b_sel", 64'(bus.sk_sel), 64'(esel));
            chk("b2b_last", 64'(bus.sk_last), 64'(got % 16 == 15));
            got++;
         end else if (seen) begin
            gap++;
         end
         if (bus.start_valid && bus.start_ready) started++;
         step();
         cyc++;
      end
      bus.start_valid = 1'b0;
      bus.sk_ready    = 1'b0;
      chk("b2b_count", 64'(got), 64'd48);
      chk("b2b_gap", 64'(gap), 64'd0);
      #1;
      chk("b2b_idle_after", 64'(bus.sk_valid), 64'd0);

      // Weak-key flag and out-of-range writes
      kw = 64'h0101010101010101;
      write_key(0, ka);
      write_key(2, kw);
      chk("weak_flag_set", 64'(key_weak[2]), 64'(WEAK_ON));
      chk("weak_flag_others", 64'(key_weak[1:0]), 64'd0);
      do_run(2, 1'b0, kw, 10, -1, 1'b0, 64'd0, fs, fr, ls, lr);
      write_key(3, 64'h133457799BBCDFF1);
      chk("oob_write_flag", 64'(key_weak[2]), 64'(WEAK_ON));
      do_run(0, 1'b1, ka, 10, -1, 1'b0, 64'd0, fs, fr, ls, lr);
      write_key(2, 64'h133457799BBCDFF1);
      chk("weak_flag_cleared", 64'(key_weak), 64'd0);

      // Random keys, slots, directions and stalls
      for (int t = 0; t < 100; t++) begin
         int  s;
         bit  d;
         ka = {$urandom, $urandom};
         s  = $urandom_range(2);
         d  = 1'($urandom_range(1));
         write_key(s, ka);
         do_run(s, d, ka, 30, -1, 1'b0, 64'd0, fs, fr, ls, lr);
      end

      // Reset in the middle of a run
      write_key(2, kb);
      bus.start_valid = 1'b1; bus.start_sel = 2'd2; bus.start_decrypt = 1'b0; bus.sk_ready = 1'b1;
      step();
      bus.start_valid = 1'b0;
      step();
      step();
      chk("pre_rst_valid", 64'(bus.sk_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_sk_valid", 64'(bus.sk_valid), 64'd0);
      chk("midrst_start_ready", 64'(bus.start_ready), 64'd1);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_subkey", 64'(bus.subkey), 64'd0);
      chk("midrst_sk_sel", 64'(bus.sk_sel), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      bus.sk_ready = 1'b0;
      step();
      chk("midrst_no_reemit", 64'(bus.sk_valid), 64'd0);
      do_run(2, 1'b0, 64'd0, 0, -1, 1'b0, 64'd0, fs, fr, ls, lr);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
